// File: rtl/counter_pkg.sv
// Shared definitions for the counter seek controller.
//   DEFAULT_WIDTH : default counter width (position wraps modulo 2**width)
//   state_t       : controller FSM encoding
//   mod_up_dist   : distance from pos up to target, modulo 2**width
package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counting upward from pos, the number of steps needed to land on target.
  // The arguments are 32-bit so that any counter width can share one helper.
  function automatic int unsigned mod_up_dist(input int unsigned target,
                                              input int unsigned pos,
                                              input int unsigned width);
    int unsigned mask;
    mask = (32'd1 << width) - 32'd1;
    return (target - pos) & mask;
  endfunction

endpackage

// File: rtl/updown_counter_en.sv
// Modulo up/down counter with enable.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears count to 0
//   enable  : step on this edge when high
//   m       : direction, 1 = up, 0 = down (wraps modulo 2**WIDTH)
//   count   : registered counter value
module updown_counter_en #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             m,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= m ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_seek_ctrl.sv
// Seek sequencer: arbitrates two clients round-robin, then drives a shared
// up/down counter to the granted target along the shortest modular path.
//   clock, reset_n            : clock and asynchronous active-low reset
//   req_valid[1:0]            : requester i has a target pending
//   req_target0/req_target1   : targets of requesters 0 and 1
//   req_ready[1:0]            : requester i's target accepted this cycle
//   position                  : current counter value (registered)
//   dir_m                     : direction in use, 1 = up, 0 = down
//   busy                      : controller is not IDLE
//   done / done_id            : one-cycle arrival pulse and served requester
module counter_seek_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_target0,
  input  logic [WIDTH-1:0] req_target1,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] position,
  output logic             dir_m,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  // Half the ring; a distance of exactly half is resolved upward.
  localparam int unsigned HALF = 32'd1 << (WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target_q;
  logic             id_q;
  logic             last_grant;

  logic             grant;
  logic [WIDTH-1:0] grant_target;
  int unsigned      up_dist;
  logic [WIDTH-1:0] step_pos;
  logic             take;

  // Round-robin: on contention the requester not served last time wins.
  always_comb begin
    grant        = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    grant_target = grant ? req_target1 : req_target0;
    up_dist      = mod_up_dist(32'(grant_target), 32'(position), unsigned'(WIDTH));
    // Value the counter will hold after this edge's step.
    step_pos     = dir_m ? position + WIDTH'(1) : position - WIDTH'(1);
    take         = (state == IDLE) && (req_valid != 2'b00);
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    unique case (state)
      IDLE: if (take) state_nxt = (up_dist == 0) ? DONE : MOVE;
      MOVE: if (step_pos == target_q) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Held off during reset so nothing is offered while the block is cleared.
    if (take && reset_n) req_ready[grant] = 1'b1;
    busy    = (state != IDLE);
    done    = (state == DONE);
    done_id = done ? id_q : 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      target_q   <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      dir_m      <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take) begin
        target_q <= grant_target;
        id_q     <= grant;
        // Zero distance means no move, so the previous direction is kept.
        if (up_dist != 0) dir_m <= (up_dist <= HALF);
      end
      if (state == DONE) last_grant <= id_q;
    end
  end

  updown_counter_en #(.WIDTH(WIDTH)) u_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (state == MOVE),
    .m      (dir_m),
    .count  (position)
  );

endmodule
